color_frame_classifier: RTL and testbench
=========================================

Name: color_frame_classifier

Overview:
- Upstream stage of the colour/node change detector. Drives the TCS3200-style colour sensor's filter selects (s2/s3) and counts sensor_out pulses over a fixed gate window for each of red, green and blue.
- Classifies each R/G/B frame into a 3-bit colour code and publishes it on color with a data_set_done qualifier, which the change detector consumes directly.

Parameters:
- GATE_CYCLES, 50000: clk cycles per counting window (1 ms at 50 MHz).
- SETTLE_CYCLES, 500: clk cycles after a filter change before counting starts.
- CNT_W, 16: width of each channel pulse counter; counters saturate.
- MIN_COUNT, 20: winning channel count must be >= this, else "no colour".
- MARGIN, 8: winning count must exceed the second-highest count by >= MARGIN, else "no colour".

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sensor_out  input  1  raw sensor frequency output, asynchronous to clk.
- s2  output  1  sensor filter select bit S2.
- s3  output  1  sensor filter select bit S3.
- color  output  3  colour code: 0 = none, 1 = red, 2 = green, 3 = blue; 4..7 never driven.
- data_set_done  output  1  high once the first frame has been classified; remains high until reset.

Behaviour:
- Reset (rst=1 at posedge): state=SEL_R, s2=0, s3=0, color=0, data_set_done=0, all counters and timers=0. Reset mid-frame discards any partial counts.
- sensor_out passes through a 2-FF synchroniser plus an edge register. A rising edge is a sync 0→1 transition; each rising edge counts once.
- Filter encoding:
  - red: s2=0, s3=0
  - green: s2=1, s3=1
  - blue: s2=0, s3=1
  - clear (s2=1, s3=0) is never used.
- FSM sequence: SEL_R → CNT_R → SEL_G → CNT_G → SEL_B → CNT_B → DECIDE → SEL_R.
  - SEL_x: set s2/s3 for channel x on entry; hold for exactly SETTLE_CYCLES cycles; edges ignored; channel counter cleared.
  - CNT_x: lasts exactly GATE_CYCLES cycles; each detected rising edge increments cnt_x. At 2^CNT_W−1 the counter holds (saturates, no wrap).
  - DECIDE: exactly 1 cycle. Computes the code; color and data_set_done update on the posedge that leaves DECIDE.
  - Frame length = 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles.
- Decision rule:
  - max = largest of cnt_r, cnt_g, cnt_b; second = next largest.
  - If max < MIN_COUNT, code = 0.
  - Else if max − second < MARGIN, code = 0. This includes exact ties.
  - Else code = index of max (1/2/3).
- color is otherwise stable: it changes only on the DECIDE exit edge and holds between decisions.
- data_set_done rises on the first DECIDE exit after reset and stays at 1.
- Edges falling within 2 cycles of a window boundary may land in either window; this is acceptable.

Optional Feature:
- CLASSIFY_HYST_EN defined:
  - The DECIDE result is compared with the previous frame's raw result.
  - color updates only when two consecutive frames give the same code; otherwise color holds.
  - The raw-result register resets to 0.
  - data_set_done still rises on the first DECIDE exit, with color=0 at that point unless confirmed.
- Undefined: color takes each frame's result directly.

Test Plan (GATE_CYCLES=100, SETTLE_CYCLES=4, MIN_COUNT=5, MARGIN=3, CNT_W=8; frame = 313 cycles):
- Reset then idle sensor_out=0 for one frame → s2/s3 sequence 00, 11, 01 at cycles 0/104/208; at cycle 313 color=0, data_set_done=1.
- 30 edges in red window, 10 in green, 10 in blue → color=1 after frame end; s2=s3=0 again at the start of the next frame.
- R=10, G=12, B=25 → color=3. Next frame R=10, G=12, B=13 (margin 1 < 3) → color=0.
- R=4, G=3, B=2 (max < MIN_COUNT) → color=0. R=G=20, B=0 (tie) → color=0.
- 300 edges in green window, others 0 → cnt_g saturates at 255, no wrap, color=2. Assert rst mid-CNT_G in the next frame → color=0, data_set_done=0, s2=s3=0 on the following cycle.
- CLASSIFY_HYST_EN: frames red, green, green → color 0 after frame 1, 0 after frame 2, 2 after frame 3.

Source files
------------

// File: rtl/color_frame_classifier.sv
// rtl/color_frame_classifier.sv - TCS3200-style colour sensor frame sampler and R/G/B classifier
//
// Purpose: steps the sensor filter through red, green and blue. Each colour gets a
//   settle interval followed by a fixed gate window in which sensor_out rising edges
//   are counted. One DECIDE cycle then turns the three counts into a colour code.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   sensor_out    in   raw sensor frequency output, asynchronous to clk
//   s2, s3        out  sensor filter selects (red 00, green 11, blue 01)
//   color[2:0]    out  0 none, 1 red, 2 green, 3 blue; updates only when DECIDE is left
//   data_set_done out  high from the first classified frame until reset
// Optional build macro: CLASSIFY_HYST_EN. When it is defined, color only takes a code
//   that two consecutive frames agree on.
module color_frame_classifier #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 500,
  parameter int CNT_W         = 16,
  parameter int MIN_COUNT     = 20,
  parameter int MARGIN        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_out,
  output logic       s2,
  output logic       s3,
  output logic [2:0] color,
  output logic       data_set_done
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    SEL_R, CNT_R, SEL_G, CNT_G, SEL_B, CNT_B, DECIDE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic             w_state_done;
  logic             r_sync1, r_sync2, r_sync3;
  logic             w_rise;
  logic [CNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b;
  logic [CNT_W-1:0] w_max, w_second;
  logic [1:0]       w_idx;
  logic [2:0]       w_code;
  logic             r_s2, r_s3;
  logic [2:0]       r_color;
  logic             r_done;

  // Two flops resynchronise sensor_out; the third holds the previous level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sensor_out;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end
  assign w_rise = r_sync2 & ~r_sync3;

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEL_R;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_done = 1'b0;
    w_state_next = r_state;
    case (r_state)
      SEL_R, SEL_G, SEL_B: w_state_done = (r_timer == TMR_W'(SETTLE_CYCLES - 1));
      CNT_R, CNT_G, CNT_B: w_state_done = (r_timer == TMR_W'(GATE_CYCLES - 1));
      default:             w_state_done = 1'b1;
    endcase
    if (w_state_done) begin
      case (r_state)
        SEL_R:   w_state_next = CNT_R;
        CNT_R:   w_state_next = SEL_G;
        SEL_G:   w_state_next = CNT_G;
        CNT_G:   w_state_next = SEL_B;
        SEL_B:   w_state_next = CNT_B;
        CNT_B:   w_state_next = DECIDE;
        default: w_state_next = SEL_R;
      endcase
    end
  end

  // Cycles spent in the current state. It restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || w_state_done) r_timer <= '0;
    else                     r_timer <= r_timer + 1'b1;
  end

  // The filter selects are decoded from the next state. They therefore change on the
  // same edge that enters the matching SEL state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      case (w_state_next)
        SEL_G, CNT_G: begin r_s2 <= 1'b1; r_s3 <= 1'b1; end
        SEL_B, CNT_B: begin r_s2 <= 1'b0; r_s3 <= 1'b1; end
        default:      begin r_s2 <= 1'b0; r_s3 <= 1'b0; end
      endcase
    end
  end

  // Saturating per-channel counters. Each one is cleared during its own SEL state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else begin
      case (r_state)
        SEL_R: r_cnt_r <= '0;
        SEL_G: r_cnt_g <= '0;
        SEL_B: r_cnt_b <= '0;
        CNT_R: if (w_rise && (r_cnt_r != '1)) r_cnt_r <= r_cnt_r + 1'b1;
        CNT_G: if (w_rise && (r_cnt_g != '1)) r_cnt_g <= r_cnt_g + 1'b1;
        CNT_B: if (w_rise && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + 1'b1;
        default: ;
      endcase
    end
  end

  // A tie for the largest count leaves w_second equal to w_max. That zero difference
  // fails the margin test, so ties always give "no colour".
  always_comb begin
    w_idx    = 2'd1;
    w_max    = r_cnt_r;
    w_second = (r_cnt_g >= r_cnt_b) ? r_cnt_g : r_cnt_b;
    if ((r_cnt_g > r_cnt_r) && (r_cnt_g >= r_cnt_b)) begin
      w_idx    = 2'd2;
      w_max    = r_cnt_g;
      w_second = (r_cnt_r >= r_cnt_b) ? r_cnt_r : r_cnt_b;
    end else if ((r_cnt_b > r_cnt_r) && (r_cnt_b > r_cnt_g)) begin
      w_idx    = 2'd3;
      w_max    = r_cnt_b;
      w_second = (r_cnt_r >= r_cnt_g) ? r_cnt_r : r_cnt_g;
    end
    w_code = {1'b0, w_idx};
    if (w_max < CNT_W'(MIN_COUNT))                 w_code = 3'd0;
    else if ((w_max - w_second) < CNT_W'(MARGIN))  w_code = 3'd0;
  end

`ifdef CLASSIFY_HYST_EN
  logic [2:0] r_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= 3'd0;
      r_raw   <= 3'd0;
      r_done  <= 1'b0;
    end else if (r_state == DECIDE) begin
      if (w_code == r_raw) r_color <= w_code;
      r_raw  <= w_code;
      r_done <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= 3'd0;
      r_done  <= 1'b0;
    end else if (r_state == DECIDE) begin
      r_color <= w_code;
      r_done  <= 1'b1;
    end
  end
`endif

  assign s2            = r_s2;
  assign s3            = r_s3;
  assign color         = r_color;
  assign data_set_done = r_done;

endmodule

// File: tb/tb_color_frame_classifier.sv
// tb/tb_color_frame_classifier.sv - directed self-checking bench for color_frame_classifier
module tb_color_frame_classifier;

  localparam int SETTLE = 4;
  localparam int GATE_A = 100;
  localparam int GATE_B = 700;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       sensor = 1'b0;
  logic       use_sat = 1'b0;
  logic       s2_a, s3_a, done_a, s2_b, s3_b, done_b;
  logic [2:0] color_a, color_b;
  logic       w_s2, w_s3, w_done;
  logic [2:0] w_color;

  int checks = 0;
  int failures = 0;
  int exp_color = 0;
  int exp_raw = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  color_frame_classifier #(
    .GATE_CYCLES(GATE_A), .SETTLE_CYCLES(SETTLE), .CNT_W(8), .MIN_COUNT(5), .MARGIN(3)
  ) u_dut (
    .clk(clk), .rst(rst_a), .sensor_out(sensor),
    .s2(s2_a), .s3(s3_a), .color(color_a), .data_set_done(done_a)
  );

  // A longer gate window allows 300 edges, which is enough to saturate an 8-bit counter.
  color_frame_classifier #(
    .GATE_CYCLES(GATE_B), .SETTLE_CYCLES(SETTLE), .CNT_W(8), .MIN_COUNT(5), .MARGIN(3)
  ) u_sat (
    .clk(clk), .rst(rst_b), .sensor_out(sensor),
    .s2(s2_b), .s3(s3_b), .color(color_b), .data_set_done(done_b)
  );

  assign w_s2    = use_sat ? s2_b    : s2_a;
  assign w_s3    = use_sat ? s3_b    : s3_a;
  assign w_color = use_sat ? color_b : color_a;
  assign w_done  = use_sat ? done_b  : done_a;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit into cycle 0 of the first frame.
  task automatic do_reset();
    sensor = 1'b0;
    if (use_sat) rst_b = 1'b1; else rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (use_sat) rst_b = 1'b0; else rst_a = 1'b0;
    exp_color = 0;
    exp_raw   = 0;
    exp_done  = 0;
  endtask

  // Runs one whole frame from cycle 0. It sends n one-cycle pulses well inside each
  // gate window, then checks the published result at cycle 0 of the next frame.
  task automatic run_frame(input int gate, input int nr, input int ng, input int nb,
                           input int code);
    int per, ch, off, v;
    int n [3];
    n[0] = nr; n[1] = ng; n[2] = nb;
    per = SETTLE + gate;
    for (int cyc = 0; cyc < 3 * per + 1; cyc++) begin
      v  = 0;
      ch = cyc / per;
      if (ch < 3) begin
        off = cyc - ch * per - SETTLE;
        if (off >= 3 && off < 3 + 2 * n[ch] && ((off - 3) % 2) == 0) v = 1;
      end
      sensor = v[0];
      if (cyc == 0)       check("sel_r_s2s3", {w_s2, w_s3}, 0);
      if (cyc == per)     check("sel_g_s2s3", {w_s2, w_s3}, 3);
      if (cyc == 2 * per) check("sel_b_s2s3", {w_s2, w_s3}, 1);
      if (cyc == 3 * per) begin
        check("color_hold", w_color, exp_color);
        check("done_hold", w_done, exp_done);
      end
      @(posedge clk);
      #1;
    end
    sensor = 1'b0;
`ifdef CLASSIFY_HYST_EN
    if (code == exp_raw) exp_color = code;
    exp_raw = code;
`else
    exp_color = code;
`endif
    exp_done = 1;
    check("color", w_color, exp_color);
    check("done", w_done, exp_done);
  endtask

  initial begin
    use_sat = 1'b0;
    do_reset();
    check("rst_s2", w_s2, 0);
    check("rst_s3", w_s3, 0);
    check("rst_color", w_color, 0);
    check("rst_done", w_done, 0);

    run_frame(GATE_A, 0, 0, 0, 0);     // idle frame
    run_frame(GATE_A, 30, 10, 10, 1);  // red
    run_frame(GATE_A, 10, 12, 25, 3);  // blue
    run_frame(GATE_A, 10, 12, 13, 0);  // margin 1
    run_frame(GATE_A, 4, 3, 2, 0);     // below MIN_COUNT
    run_frame(GATE_A, 20, 20, 0, 0);   // exact tie
    run_frame(GATE_A, 10, 13, 0, 2);   // margin exactly 3
    run_frame(GATE_A, 5, 0, 0, 1);     // max exactly MIN_COUNT

    do_reset();
    run_frame(GATE_A, 30, 0, 0, 1);
    run_frame(GATE_A, 0, 30, 0, 2);
    run_frame(GATE_A, 0, 30, 0, 2);

    // Saturation: a counter that wrapped would read 44 and let red (50) win.
    rst_a   = 1'b1;
    use_sat = 1'b1;
    do_reset();
    run_frame(GATE_B, 50, 300, 0, 2);
    run_frame(GATE_B, 50, 300, 0, 2);

    // Reset in the middle of CNT_G discards the frame and clears the outputs.
    repeat (2 * SETTLE + GATE_B + 300) @(posedge clk);
    #1;
    check("mid_cnt_g_s2s3", {w_s2, w_s3}, 3);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_color", w_color, 0);
    check("midrst_done", w_done, 0);
    check("midrst_s2s3", {w_s2, w_s3}, 0);
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_done", w_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
